// File: rtl/spr_issue_arbiter.sv
// ============================================================================
// Module   : spr_issue_arbiter
// Purpose  : Per-wavefront instruction slots with round-robin issue to ALU/LSU,
//            driving the SPR busy-bit set signals of the dependency table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spr_issue_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_decode_valid,
    input  logic [WFID_W-1:0] f_decode_wfid,
    input  logic              f_decode_lsu,
    input  logic              f_decode_vcc_wr,
    input  logic              f_decode_scc_wr,
    input  logic              f_decode_exec_wr,
    input  logic              f_decode_m0_wr,
    input  logic              flush_valid,
    input  logic [WFID_W-1:0] flush_wfid,
    input  logic [NUM_WF-1:0] ready_arry_spr,
    input  logic              alu_ready,
    input  logic              lsu_ready,
    output logic [NUM_WF-1:0] slot_full,
    output logic              issued_valid,
    output logic [WFID_W-1:0] issued_wfid,
    output logic              alu_valid,
    output logic              lsu_valid,
    output logic              issue_alu_vcc_wr,
    output logic              issue_alu_scc_wr,
    output logic              issue_alu_exec_wr,
    output logic              issue_alu_m0_wr,
    output logic              issue_lsu_vcc_wr,
    output logic              issue_lsu_scc_wr,
    output logic              issue_lsu_exec_wr,
    output logic              issue_lsu_m0_wr,
    output logic              decode_overflow
);

    // Write flags are packed {vcc, scc, exec, m0}.
    logic [NUM_WF-1:0] r_slot_valid;
    logic [NUM_WF-1:0] r_slot_lsu;
    logic [3:0]        r_slot_flags [NUM_WF];
    logic [WFID_W-1:0] r_rr_ptr;

    logic              r_issued_valid;
    logic [WFID_W-1:0] r_issued_wfid;
    logic              r_alu_valid;
    logic              r_lsu_valid;
    logic [3:0]        r_alu_flags;
    logic [3:0]        r_lsu_flags;
    logic              r_overflow;

    logic [NUM_WF-1:0] w_flush_hit;
    logic [NUM_WF-1:0] w_elig;
    logic [NUM_WF-1:0] w_upper;
    logic              w_hi_found;
    logic [WFID_W-1:0] w_hi_id;
    logic              w_lo_found;
    logic [WFID_W-1:0] w_lo_id;
    logic              w_win_valid;
    logic [WFID_W-1:0] w_win_id;
    logic              w_win_lsu;
    logic [3:0]        w_win_flags;
    logic [WFID_W-1:0] w_rr_next;

    logic              w_dec_in_range;
    logic              w_dec_busy;
    logic              w_dec_flush_hit;
    logic              w_dec_issue_hit;
    logic              w_dec_accept;
    logic              w_dec_overflow;
    logic [3:0]        w_dec_flags;

    assign w_dec_flags = {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr};

    always_comb begin
        w_flush_hit = '0;
        w_elig      = '0;
        w_upper     = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            w_flush_hit[i] = flush_valid && (int'(flush_wfid) == i);
            w_elig[i]      = r_slot_valid[i] && ready_arry_spr[i]
                             && (r_slot_lsu[i] ? lsu_ready : alu_ready)
                             && !w_flush_hit[i];
            w_upper[i]     = w_elig[i] && (i >= int'(r_rr_ptr));
        end
    end

    // Lowest eligible index at or above the pointer wins; otherwise wrap to
    // the lowest eligible index overall.
    always_comb begin
        w_hi_found  = 1'b0;
        w_hi_id     = '0;
        w_lo_found  = 1'b0;
        w_lo_id     = '0;
        w_win_lsu   = 1'b0;
        w_win_flags = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (w_upper[i]) begin
                w_hi_found = 1'b1;
                w_hi_id    = WFID_W'(i);
            end
            if (w_elig[i]) begin
                w_lo_found = 1'b1;
                w_lo_id    = WFID_W'(i);
            end
        end
        w_win_valid = w_hi_found || w_lo_found;
        w_win_id    = w_hi_found ? w_hi_id : w_lo_id;
        for (int i = 0; i < NUM_WF; i++) begin
            if (w_win_valid && (int'(w_win_id) == i)) begin
                w_win_lsu   = r_slot_lsu[i];
                w_win_flags = r_slot_flags[i];
            end
        end
        w_rr_next = (w_win_id == WFID_W'(NUM_WF - 1)) ? '0 : w_win_id + 1'b1;
    end

    always_comb begin
        w_dec_busy = 1'b0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (int'(f_decode_wfid) == i) begin
                w_dec_busy = r_slot_valid[i];
            end
        end
    end

    assign w_dec_in_range  = int'(f_decode_wfid) < NUM_WF;
    assign w_dec_flush_hit = flush_valid && (flush_wfid == f_decode_wfid);
    assign w_dec_issue_hit = w_win_valid && (w_win_id == f_decode_wfid);
    assign w_dec_accept    = f_decode_valid && w_dec_in_range && !w_dec_flush_hit
                             && (!w_dec_busy || w_dec_issue_hit);
    assign w_dec_overflow  = f_decode_valid && w_dec_in_range
                             && (w_dec_flush_hit || (w_dec_busy && !w_dec_issue_hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_valid <= '0;
            r_rr_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                if ((w_win_valid && (int'(w_win_id) == i)) || w_flush_hit[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
                if (w_dec_accept && (int'(f_decode_wfid) == i)) begin
                    r_slot_valid[i] <= 1'b1;
                end
            end
            if (w_win_valid) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_dec_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload is only meaningful while the slot valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WF; i++) begin
            if (w_dec_accept && (int'(f_decode_wfid) == i)) begin
                r_slot_lsu[i]   <= f_decode_lsu;
                r_slot_flags[i] <= w_dec_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_valid <= 1'b0;
            r_issued_wfid  <= '0;
            r_alu_valid    <= 1'b0;
            r_lsu_valid    <= 1'b0;
            r_alu_flags    <= '0;
            r_lsu_flags    <= '0;
        end else begin
            r_issued_valid <= w_win_valid;
            r_alu_valid    <= w_win_valid && !w_win_lsu;
            r_lsu_valid    <= w_win_valid && w_win_lsu;
            r_alu_flags    <= (w_win_valid && !w_win_lsu) ? w_win_flags : 4'b0000;
            r_lsu_flags    <= (w_win_valid && w_win_lsu) ? w_win_flags : 4'b0000;
            if (w_win_valid) begin
                r_issued_wfid <= w_win_id;
            end
        end
    end

    assign slot_full         = r_slot_valid;
    assign issued_valid      = r_issued_valid;
    assign issued_wfid       = r_issued_wfid;
    assign alu_valid         = r_alu_valid;
    assign lsu_valid         = r_lsu_valid;
    assign issue_alu_vcc_wr  = r_alu_flags[3];
    assign issue_alu_scc_wr  = r_alu_flags[2];
    assign issue_alu_exec_wr = r_alu_flags[1];
    assign issue_alu_m0_wr   = r_alu_flags[0];
    assign issue_lsu_vcc_wr  = r_lsu_flags[3];
    assign issue_lsu_scc_wr  = r_lsu_flags[2];
    assign issue_lsu_exec_wr = r_lsu_flags[1];
    assign issue_lsu_m0_wr   = r_lsu_flags[0];
    assign decode_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_spr_issue_arbiter.sv
// ============================================================================
// Module   : tb_spr_issue_arbiter
// Purpose  : Directed stimulus with a scoreboard queue checked by an issue monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spr_issue_arbiter;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    typedef struct packed {
        logic [WFID_W-1:0] wfid;
        logic              lsu;
        logic [3:0]        flags;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              f_decode_valid;
    logic [WFID_W-1:0] f_decode_wfid;
    logic              f_decode_lsu;
    logic              f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr;
    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;
    logic [NUM_WF-1:0] ready_arry_spr;
    logic              alu_ready, lsu_ready;
    logic [NUM_WF-1:0] slot_full;
    logic              issued_valid;
    logic [WFID_W-1:0] issued_wfid;
    logic              alu_valid, lsu_valid;
    logic              issue_alu_vcc_wr, issue_alu_scc_wr, issue_alu_exec_wr, issue_alu_m0_wr;
    logic              issue_lsu_vcc_wr, issue_lsu_scc_wr, issue_lsu_exec_wr, issue_lsu_m0_wr;
    logic              decode_overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    spr_issue_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .f_decode_valid    (f_decode_valid),
        .f_decode_wfid     (f_decode_wfid),
        .f_decode_lsu      (f_decode_lsu),
        .f_decode_vcc_wr   (f_decode_vcc_wr),
        .f_decode_scc_wr   (f_decode_scc_wr),
        .f_decode_exec_wr  (f_decode_exec_wr),
        .f_decode_m0_wr    (f_decode_m0_wr),
        .flush_valid       (flush_valid),
        .flush_wfid        (flush_wfid),
        .ready_arry_spr    (ready_arry_spr),
        .alu_ready         (alu_ready),
        .lsu_ready         (lsu_ready),
        .slot_full         (slot_full),
        .issued_valid      (issued_valid),
        .issued_wfid       (issued_wfid),
        .alu_valid         (alu_valid),
        .lsu_valid         (lsu_valid),
        .issue_alu_vcc_wr  (issue_alu_vcc_wr),
        .issue_alu_scc_wr  (issue_alu_scc_wr),
        .issue_alu_exec_wr (issue_alu_exec_wr),
        .issue_alu_m0_wr   (issue_alu_m0_wr),
        .issue_lsu_vcc_wr  (issue_lsu_vcc_wr),
        .issue_lsu_scc_wr  (issue_lsu_scc_wr),
        .issue_lsu_exec_wr (issue_lsu_exec_wr),
        .issue_lsu_m0_wr   (issue_lsu_m0_wr),
        .decode_overflow   (decode_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge; presents one decode for exactly one cycle.
    task automatic dec(input int w, input logic l, input logic [3:0] f);
        f_decode_valid = 1'b1;
        f_decode_wfid  = WFID_W'(w);
        f_decode_lsu   = l;
        {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr} = f;
        @(negedge clk);
        f_decode_valid = 1'b0;
    endtask

    task automatic expect_issue(input int w, input logic l, input logic [3:0] f);
        exp_t e;
        e.wfid  = WFID_W'(w);
        e.lsu   = l;
        e.flags = f;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_arry_spr = '1;
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
    endtask

    // Monitor: every issue pulse must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (issued_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got wfid %0d, no issue expected at %0t", issued_wfid, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("issue_payload",
                    {50'd0, issued_wfid, alu_valid, lsu_valid,
                     issue_alu_vcc_wr, issue_alu_scc_wr, issue_alu_exec_wr, issue_alu_m0_wr,
                     issue_lsu_vcc_wr, issue_lsu_scc_wr, issue_lsu_exec_wr, issue_lsu_m0_wr},
                    {50'd0, e.wfid, !e.lsu, e.lsu,
                     (e.lsu ? 4'b0000 : e.flags), (e.lsu ? e.flags : 4'b0000)});
            end
        end else begin
            chk("idle_outputs_zero",
                {54'd0, alu_valid, lsu_valid,
                 issue_alu_vcc_wr, issue_alu_scc_wr, issue_alu_exec_wr, issue_alu_m0_wr,
                 issue_lsu_vcc_wr, issue_lsu_scc_wr, issue_lsu_exec_wr, issue_lsu_m0_wr},
                64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        f_decode_valid = 1'b0;
        f_decode_wfid  = '0;
        f_decode_lsu   = 1'b0;
        {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr} = 4'b0000;
        flush_valid    = 1'b0;
        flush_wfid     = '0;
        ready_arry_spr = '1;
        alu_ready      = 1'b1;
        lsu_ready      = 1'b1;

        #3;
        chk("reset_issued_valid", 64'(issued_valid), 64'd0);
        chk("reset_issued_wfid", 64'(issued_wfid), 64'd0);
        chk("reset_slot_full", 64'(slot_full), 64'd0);
        chk("reset_overflow", 64'(decode_overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First issue two cycles after decode
        @(negedge clk);
        expect_issue(5, 1'b0, 4'b0100);
        dec(5, 1'b0, 4'b0100);
        chk("wf5_slot_full_set", 64'(slot_full[5]), 64'd1);
        chk("wf5_not_yet_issued", 64'(issued_valid), 64'd0);
        @(negedge clk);
        chk("wf5_issued", {57'd0, issued_valid, issued_wfid}, {57'd0, 1'b1, 6'd5});
        chk("wf5_alu_scc", {62'd0, alu_valid, issue_alu_scc_wr}, 64'd3);
        chk("wf5_slot_full_clr", 64'(slot_full[5]), 64'd0);

        // Asynchronous reset during an issue pulse with a held slot
        ready_arry_spr[9] = 1'b0;
        dec(9, 1'b0, 4'b1111);
        expect_issue(6, 1'b0, 4'b1000);
        dec(6, 1'b0, 4'b1000);
        @(posedge clk);
        #2;
        chk("pre_reset_pulse", 64'(issued_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_kills_pulse",
            {58'd0, issued_valid, alu_valid, issue_alu_vcc_wr, lsu_valid, decode_overflow, 1'b0},
            64'd0);
        chk("async_reset_slots", 64'(slot_full), 64'd0);
        chk("async_reset_wfid", 64'(issued_wfid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_arry_spr = '1;

        // Round robin with wrap: move pointer to 21, then 3/20/39 compete
        @(negedge clk);
        expect_issue(20, 1'b0, 4'b0001);
        dec(20, 1'b0, 4'b0001);
        cyc(2);
        ready_arry_spr[3] = 1'b0;
        ready_arry_spr[20] = 1'b0;
        ready_arry_spr[39] = 1'b0;
        dec(3, 1'b0, 4'b1000);
        dec(20, 1'b1, 4'b0110);
        dec(39, 1'b0, 4'b0001);
        expect_issue(39, 1'b0, 4'b0001);
        expect_issue(3, 1'b0, 4'b1000);
        expect_issue(20, 1'b1, 4'b0110);
        ready_arry_spr = '1;
        @(negedge clk);
        chk("rr_first_39", {57'd0, issued_valid, issued_wfid}, {57'd0, 1'b1, 6'd39});
        @(negedge clk);
        chk("rr_second_3", {57'd0, issued_valid, issued_wfid}, {57'd0, 1'b1, 6'd3});
        @(negedge clk);
        chk("rr_third_20", {57'd0, issued_valid, issued_wfid}, {57'd0, 1'b1, 6'd20});
        // Pointer now 21: 22 must beat 20
        ready_arry_spr[20] = 1'b0;
        ready_arry_spr[22] = 1'b0;
        dec(20, 1'b0, 4'b0000);
        dec(22, 1'b0, 4'b1111);
        expect_issue(22, 1'b0, 4'b1111);
        expect_issue(20, 1'b0, 4'b0000);
        ready_arry_spr = '1;
        cyc(4);

        // Unit and readiness gating
        lsu_ready = 1'b0;
        ready_arry_spr[8] = 1'b0;
        dec(7, 1'b1, 4'b1010);
        dec(8, 1'b0, 4'b0001);
        cyc(3);
        chk("gated_slots_held", {62'd0, slot_full[7], slot_full[8]}, 64'd3);
        expect_issue(7, 1'b1, 4'b1010);
        lsu_ready = 1'b1;
        @(negedge clk);
        chk("wf7_lsu_issue", {55'd0, issued_valid, alu_valid, lsu_valid, issued_wfid},
            {55'd0, 1'b1, 1'b0, 1'b1, 6'd7});
        expect_issue(8, 1'b0, 4'b0001);
        ready_arry_spr[8] = 1'b1;
        cyc(3);

        // Flush in the selection cycle
        f_decode_valid = 1'b1;
        f_decode_wfid  = 6'd10;
        f_decode_lsu   = 1'b0;
        {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr} = 4'b1111;
        @(negedge clk);
        f_decode_valid = 1'b0;
        flush_valid = 1'b1;
        flush_wfid  = 6'd10;
        @(negedge clk);
        flush_valid = 1'b0;
        chk("flush_no_issue", 64'(issued_valid), 64'd0);
        chk("flush_clears_slot", 64'(slot_full[10]), 64'd0);
        chk("overflow_still_clear", 64'(decode_overflow), 64'd0);
        // Flush and decode together
        f_decode_valid = 1'b1;
        flush_valid    = 1'b1;
        @(negedge clk);
        f_decode_valid = 1'b0;
        flush_valid    = 1'b0;
        chk("flush_decode_slot_empty", 64'(slot_full[10]), 64'd0);
        chk("flush_decode_overflow", 64'(decode_overflow), 64'd1);
        cyc(2);

        // Out-of-range wfid is ignored
        do_reset();
        dec(45, 1'b0, 4'b1111);
        cyc(2);
        chk("oor_no_slot", 64'(slot_full), 64'd0);
        chk("oor_no_overflow", 64'(decode_overflow), 64'd0);

        // Decode into an occupied slot
        ready_arry_spr[12] = 1'b0;
        dec(12, 1'b0, 4'b1000);
        dec(12, 1'b1, 4'b0100);
        chk("occupied_overflow", 64'(decode_overflow), 64'd1);
        chk("occupied_slot_held", 64'(slot_full[12]), 64'd1);
        expect_issue(12, 1'b0, 4'b1000);
        ready_arry_spr[12] = 1'b1;
        cyc(3);
        chk("overflow_sticky", 64'(decode_overflow), 64'd1);
        chk("wf12_drained", 64'(slot_full[12]), 64'd0);

        // Issue and decode of the same wavefront
        do_reset();
        expect_issue(2, 1'b0, 4'b0010);
        expect_issue(2, 1'b1, 4'b0001);
        f_decode_valid = 1'b1;
        f_decode_wfid  = 6'd2;
        f_decode_lsu   = 1'b0;
        {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr} = 4'b0010;
        @(negedge clk);
        f_decode_lsu = 1'b1;
        {f_decode_vcc_wr, f_decode_scc_wr, f_decode_exec_wr, f_decode_m0_wr} = 4'b0001;
        @(negedge clk);
        f_decode_valid = 1'b0;
        chk("reload_slot_full", 64'(slot_full[2]), 64'd1);
        chk("reload_no_overflow", 64'(decode_overflow), 64'd0);
        cyc(4);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        chk("final_slots_empty", 64'(slot_full), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
